// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM: sequences FETCH/DECODE/EXECUTE/MEM/WB with a memory ready
// handshake, memory wait timeout, halt at instruction boundaries and an illegal-opcode trap.
module multicycle_control_unit #(
    parameter int OPCODE_W    = 6,
    parameter int ALU_OP_W    = 3,
    parameter int MEM_TIMEOUT = 16,
    parameter logic [OPCODE_W-1:0] OP_RTYPE = 'h00,
    parameter logic [OPCODE_W-1:0] OP_ADDI  = 'h01,
    parameter logic [OPCODE_W-1:0] OP_IMM   = 'h02,
    parameter logic [OPCODE_W-1:0] OP_LW    = 'h04,
    parameter logic [OPCODE_W-1:0] OP_SW    = 'h05,
    parameter logic [OPCODE_W-1:0] OP_BEQ   = 'h06
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    input  logic                halt,
    output logic                pc_write,
    output logic                branch,
    output logic                ir_write,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                instr_done,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [3:0]          state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WR = 4'd6,
        S_WB_R   = 4'd7,
        S_WB_I   = 4'd8,
        S_WB_MEM = 4'd9,
        S_BRANCH = 4'd10,
        S_TRAP   = 4'd15
    } state_t;

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    localparam logic [ALU_OP_W-1:0] ALU_FUNCT = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_SUB   = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_ADDI  = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] ALU_ADD   = ALU_OP_W'(3);

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    state_t              state_q;
    logic [CNT_W-1:0]    wait_cnt_q;
    logic [1:0]          trap_cause_q;
    logic [OPCODE_W-1:0] op_q;
    logic                timeout_hit;

    // The last permitted wait cycle; mem_ready on that same cycle still completes normally.
    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt_q == CNT_LAST) && !mem_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            wait_cnt_q   <= '0;
            trap_cause_q <= 2'b00;
            op_q         <= '0;
        end else begin
            wait_cnt_q <= '0;
            case (state_q)
                S_FETCH: begin
                    if (!halt) begin
                        if (mem_ready) begin
                            state_q <= S_DECODE;
                        end else if (timeout_hit) begin
                            state_q      <= S_TRAP;
                            trap_cause_q <= CAUSE_TIMEOUT;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_DECODE: begin
                    op_q <= opcode;
                    if (opcode == OP_RTYPE) begin
                        state_q <= S_EXEC_R;
                    end else if (opcode == OP_ADDI || opcode == OP_IMM) begin
                        state_q <= S_EXEC_I;
                    end else if (opcode == OP_LW || opcode == OP_SW) begin
                        state_q <= S_ADDR;
                    end else if (opcode == OP_BEQ) begin
                        state_q <= S_BRANCH;
                    end else begin
                        state_q      <= S_TRAP;
                        trap_cause_q <= CAUSE_ILLEGAL;
                    end
                end
                S_EXEC_R: state_q <= S_WB_R;
                S_EXEC_I: state_q <= S_WB_I;
                S_ADDR:   state_q <= (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD, S_MEM_WR: begin
                    if (mem_ready) begin
                        state_q <= (state_q == S_MEM_RD) ? S_WB_MEM : S_FETCH;
                    end else if (timeout_hit) begin
                        state_q      <= S_TRAP;
                        trap_cause_q <= CAUSE_TIMEOUT;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH: state_q <= S_FETCH;
                S_TRAP:   state_q <= S_TRAP;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    // Moore decode of state, forced to zero while reset is held so nothing is written mid-abort.
    always_comb begin
        pc_write   = 1'b0;
        branch     = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = ALU_FUNCT;
        instr_done = 1'b0;
        trap       = 1'b0;
        trap_cause = 2'b00;
        state      = 4'd0;
        if (rst_n) begin
            state = state_q;
            case (state_q)
                S_FETCH: begin
                    if (!halt) begin
                        mem_read  = 1'b1;
                        alu_src_b = 2'b01;
                        alu_op    = ALU_ADD;
                        pc_write  = mem_ready;
                        ir_write  = mem_ready;
                    end
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    alu_op    = ALU_ADD;
                end
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                end
                S_EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = (op_q == OP_ADDI) ? ALU_ADDI : ALU_ADD;
                end
                S_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = ALU_ADD;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write  = 1'b1;
                    i_or_d     = 1'b1;
                    instr_done = mem_ready;
                end
                S_WB_R: begin
                    reg_dst    = 1'b1;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_WB_I: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    alu_op     = (op_q == OP_ADDI) ? ALU_ADDI : ALU_ADD;
                end
                S_WB_MEM: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_op     = ALU_SUB;
                    branch     = 1'b1;
                    instr_done = 1'b1;
                end
                S_TRAP: begin
                    trap       = 1'b1;
                    trap_cause = trap_cause_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: a driver pushes the hand-computed output
// vector for each cycle, a negedge monitor pops and compares it against the DUT.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       halt;
    logic       pc_write, branch, ir_write, i_or_d, mem_read, mem_write;
    logic       reg_dst, reg_write, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       instr_done, trap;
    logic [1:0] trap_cause;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    logic [22:0] exp_q[$];
    string       name_q[$];
    logic [22:0] act;

    always #5 clk = ~clk;

    multicycle_control_unit #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .halt(halt),
        .pc_write(pc_write), .branch(branch), .ir_write(ir_write), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .reg_dst(reg_dst), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .instr_done(instr_done), .trap(trap), .trap_cause(trap_cause), .state(state)
    );

    // Vector layout: {pcw,br,irw,iord,mrd,mwr,rdst,rwr,m2r,sa, src_b, alu_op, {done,trap,cause}, state}
    localparam logic [22:0] V_ZERO      = 23'd0;
    localparam logic [22:0] V_FETCH     = {10'b1010100000, 2'b01, 3'b011, 4'b0000, 4'd0};
    localparam logic [22:0] V_FETCH_W   = {10'b0000100000, 2'b01, 3'b011, 4'b0000, 4'd0};
    localparam logic [22:0] V_DECODE    = {10'b0000000000, 2'b11, 3'b011, 4'b0000, 4'd1};
    localparam logic [22:0] V_EXEC_R    = {10'b0000000001, 2'b00, 3'b000, 4'b0000, 4'd2};
    localparam logic [22:0] V_EXEC_ADDI = {10'b0000000001, 2'b10, 3'b010, 4'b0000, 4'd3};
    localparam logic [22:0] V_EXEC_IMM  = {10'b0000000001, 2'b10, 3'b011, 4'b0000, 4'd3};
    localparam logic [22:0] V_ADDR      = {10'b0000000001, 2'b10, 3'b011, 4'b0000, 4'd4};
    localparam logic [22:0] V_MEM_RD    = {10'b0001100000, 2'b00, 3'b000, 4'b0000, 4'd5};
    localparam logic [22:0] V_MEM_WR_W  = {10'b0001010000, 2'b00, 3'b000, 4'b0000, 4'd6};
    localparam logic [22:0] V_MEM_WR_D  = {10'b0001010000, 2'b00, 3'b000, 4'b1000, 4'd6};
    localparam logic [22:0] V_WB_R      = {10'b0000001100, 2'b00, 3'b000, 4'b1000, 4'd7};
    localparam logic [22:0] V_WB_ADDI   = {10'b0000000100, 2'b00, 3'b010, 4'b1000, 4'd8};
    localparam logic [22:0] V_WB_IMM    = {10'b0000000100, 2'b00, 3'b011, 4'b1000, 4'd8};
    localparam logic [22:0] V_WB_MEM    = {10'b0000000110, 2'b00, 3'b000, 4'b1000, 4'd9};
    localparam logic [22:0] V_BRANCH    = {10'b0100000001, 2'b00, 3'b001, 4'b1000, 4'd10};
    localparam logic [22:0] V_TRAP_ILL  = {10'b0000000000, 2'b00, 3'b000, 4'b0101, 4'd15};
    localparam logic [22:0] V_TRAP_TO   = {10'b0000000000, 2'b00, 3'b000, 4'b0110, 4'd15};

    assign act = {pc_write, branch, ir_write, i_or_d, mem_read, mem_write, reg_dst, reg_write,
                  mem_to_reg, alu_src_a, alu_src_b, alu_op, instr_done, trap, trap_cause, state};

    // Monitor: every cycle the driver issued has one expected vector waiting.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [22:0] e;
            string       n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h (state got %0d expected %0d)",
                         n, act, e, state, e[3:0]);
            end
        end
    end

    task automatic step(input logic rn, input logic mr, input logic hl, input logic [5:0] op,
                        input logic [22:0] e, input string nm);
        @(posedge clk);
        #1;
        rst_n     = rn;
        mem_ready = mr;
        halt      = hl;
        opcode    = op;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic fetch_ok();
        step(1'b1, 1'b1, 1'b0, 6'h00, V_FETCH, "fetch");
    endtask

    task automatic decode(input logic [5:0] op);
        step(1'b1, 1'b1, 1'b0, op, V_DECODE, "decode");
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 6'h00, V_ZERO, "reset");
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        halt      = 1'b0;
        opcode    = 6'h00;

        do_reset();
        do_reset();

        // R-type: 0,1,2,7 then FETCH; opcode changes after DECODE are ignored
        fetch_ok();
        decode(6'h00);
        step(1'b1, 1'b1, 1'b0, 6'h3F, V_EXEC_R, "r_exec");
        step(1'b1, 1'b1, 1'b0, 6'h3F, V_WB_R, "r_wb");

        // ADDI with opcode switched to IMM during EXEC_I: alu_op stays 010
        fetch_ok();
        decode(6'h01);
        step(1'b1, 1'b1, 1'b0, 6'h02, V_EXEC_ADDI, "addi_exec");
        step(1'b1, 1'b1, 1'b0, 6'h02, V_WB_ADDI, "addi_wb");

        // IMM after one fetch wait cycle
        step(1'b1, 1'b0, 1'b0, 6'h00, V_FETCH_W, "fetch_wait");
        fetch_ok();
        decode(6'h02);
        step(1'b1, 1'b1, 1'b0, 6'h00, V_EXEC_IMM, "imm_exec");
        step(1'b1, 1'b1, 1'b0, 6'h00, V_WB_IMM, "imm_wb");

        // LW with three wait cycles in MEM_RD: 8 cycles in total
        fetch_ok();
        decode(6'h04);
        step(1'b1, 1'b1, 1'b0, 6'h00, V_ADDR, "lw_addr");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 6'h00, V_MEM_RD, "lw_mem_wait");
        step(1'b1, 1'b1, 1'b0, 6'h00, V_MEM_RD, "lw_mem_done");
        step(1'b1, 1'b1, 1'b0, 6'h00, V_WB_MEM, "lw_wb");

        // SW, zero wait
        fetch_ok();
        decode(6'h05);
        step(1'b1, 1'b1, 1'b0, 6'h00, V_ADDR, "sw_addr");
        step(1'b1, 1'b1, 1'b0, 6'h00, V_MEM_WR_D, "sw_mem_done");

        // BEQ: branch only in cycle 3
        fetch_ok();
        decode(6'h06);
        step(1'b1, 1'b1, 1'b0, 6'h00, V_BRANCH, "beq_branch");

        // Halt in FETCH for five cycles: no fetch, no PC update
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 6'h00, V_ZERO, "halt_fetch");

        // Halt raised mid-instruction lets it finish, then holds FETCH
        fetch_ok();
        decode(6'h00);
        step(1'b1, 1'b1, 1'b1, 6'h00, V_EXEC_R, "halt_mid_exec");
        step(1'b1, 1'b1, 1'b1, 6'h00, V_WB_R, "halt_mid_wb");
        step(1'b1, 1'b1, 1'b1, 6'h00, V_ZERO, "halt_after");

        // SW with ready arriving on the 4th wait cycle: completes normally
        fetch_ok();
        decode(6'h05);
        step(1'b1, 1'b1, 1'b0, 6'h00, V_ADDR, "sw4_addr");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 6'h00, V_MEM_WR_W, "sw4_wait");
        step(1'b1, 1'b1, 1'b0, 6'h00, V_MEM_WR_D, "sw4_ready_last");
        fetch_ok();

        // SW timeout: four wait cycles, then sticky TRAP cause 10
        decode(6'h05);
        step(1'b1, 1'b1, 1'b0, 6'h00, V_ADDR, "swto_addr");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 6'h00, V_MEM_WR_W, "swto_wait");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 6'h00, V_TRAP_TO, "swto_trap");
        do_reset();

        // Reset during MEM_WR: mem_write drops in the same cycle, FETCH next
        fetch_ok();
        decode(6'h05);
        step(1'b1, 1'b1, 1'b0, 6'h00, V_ADDR, "rst_addr");
        step(1'b1, 1'b0, 1'b0, 6'h00, V_MEM_WR_W, "rst_wr_wait");
        step(1'b0, 1'b0, 1'b0, 6'h00, V_ZERO, "rst_mid_wr");
        step(1'b1, 1'b1, 1'b0, 6'h00, V_FETCH, "after_rst_fetch");

        // Illegal opcode trap, sticky regardless of inputs
        decode(6'h3F);
        step(1'b1, 1'b1, 1'b0, 6'h00, V_TRAP_ILL, "ill_trap");
        step(1'b1, 1'b0, 1'b1, 6'h04, V_TRAP_ILL, "ill_trap_hold");
        step(1'b1, 1'b1, 1'b0, 6'h00, V_TRAP_ILL, "ill_trap_hold2");
        do_reset();

        // Fetch timeout: four unready fetch cycles
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 6'h00, V_FETCH_W, "fto_wait");
        step(1'b1, 1'b1, 1'b0, 6'h00, V_TRAP_TO, "fto_trap");
        do_reset();
        fetch_ok();
        decode(6'h06);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
